// File: rtl/animation_pkg.sv
// Shared definitions for the animation scheduler: register map,
// region sequencer state encoding and STATUS field offsets.
package animation_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_SEL      = 3'd2;
    localparam logic [2:0] ADDR_TIMING   = 3'd3;
    localparam logic [2:0] ADDR_REPEAT   = 3'd4;
    localparam logic [2:0] ADDR_FRAMES   = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;

    localparam int STATUS_RUN_LSB  = 0;
    localparam int STATUS_DONE_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ON,
        ST_OFF,
        ST_DONE
    } region_state_e;

endpackage

// File: rtl/anim_region_fsm.sv
// One region sequencer: holds the trigger high for on_frames frames, low
// for off_frames frames, repeated repeat_cnt times (0 = forever).
module anim_region_fsm
    import animation_pkg::*;
#(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                vs_rise,
    input  logic [CNT_BITS-1:0] on_frames,
    input  logic [CNT_BITS-1:0] off_frames,
    input  logic [15:0]         repeat_cnt,
    output logic                trigger,
    output logic                running,
    output logic                done_set
);

    region_state_e       state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [15:0]         rem_q, rem_d;
    logic                trig_q, trig_d;
    logic [CNT_BITS-1:0] on_load;

    // A zero on-length still produces a one-frame pulse
    assign on_load = (on_frames == '0) ? CNT_BITS'(1) : on_frames;

    // Next-state logic; a cleared enable overrides any frame edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        trig_d   = trig_q;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                trig_d = 1'b0;
                if (enable) begin
                    state_d = ST_ARM;
                    rem_d   = repeat_cnt;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    trig_d  = 1'b0;
                end else if (vs_rise) begin
                    state_d = ST_ON;
                    cnt_d   = on_load;
                    trig_d  = 1'b1;
                end
            end
            ST_ON, ST_OFF: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    trig_d  = 1'b0;
                end else if (vs_rise) begin
                    if (cnt_q > CNT_BITS'(1)) begin
                        cnt_d = cnt_q - CNT_BITS'(1);
                    end else if (state_q == ST_ON && off_frames != '0) begin
                        state_d = ST_OFF;
                        cnt_d   = off_frames;
                        trig_d  = 1'b0;
                    end else if (rem_q != 16'd1) begin
                        // End of cycle with repeats left (or infinite)
                        state_d = ST_ON;
                        cnt_d   = on_load;
                        trig_d  = 1'b1;
                        if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
                    end else begin
                        state_d  = ST_DONE;
                        trig_d   = 1'b0;
                        done_set = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                trig_d = 1'b0;
                if (!enable) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                trig_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, counters and registered trigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            trig_q  <= trig_d;
        end
    end

    assign trigger = trig_q;
    assign running = (state_q == ST_ARM) || (state_q == ST_ON) || (state_q == ST_OFF);

endmodule

// File: rtl/animation_scheduler.sv
// Avalon-MM programmable frame scheduler driving StandardAnimation
// event_trigger inputs. Optional IRQ (port + IRQ_MASK register) is built
// when ANIM_SCHED_IRQ_EN is defined.
module animation_scheduler
    import animation_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter int CNT_BITS    = 8
) (
    input  logic                   clock_clk,
    input  logic                   reset_rst,
    input  logic                   v_sync,
    input  logic [2:0]             s0_address,
    input  logic                   s0_write,
    input  logic [31:0]            s0_writedata,
    input  logic                   s0_read,
    output logic [31:0]            s0_readdata,
    output logic [NUM_REGIONS-1:0] event_trigger
`ifdef ANIM_SCHED_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic                   v_sync_q, vs_rise;
    logic [NUM_REGIONS-1:0] ctrl_q, ctrl_d, done_q, done_d, running, done_set;
    logic [2:0]             sel_q, sel_d;
    logic [SEL_W-1:0]       sel_idx;
    logic [CNT_BITS-1:0]    on_q [NUM_REGIONS], on_d [NUM_REGIONS];
    logic [CNT_BITS-1:0]    off_q[NUM_REGIONS], off_d[NUM_REGIONS];
    logic [15:0]            rep_q[NUM_REGIONS], rep_d[NUM_REGIONS];
    logic [31:0]            frames_q, frames_d, rdata_q, rdata_d, rd_mux;
`ifdef ANIM_SCHED_IRQ_EN
    logic [7:0]             irq_mask_q, irq_mask_d;
    logic                   irq_q, irq_d;
`endif
    logic                   unused_wdata;

    assign vs_rise      = v_sync & ~v_sync_q;
    assign sel_idx      = sel_q[SEL_W-1:0];
    assign unused_wdata = ^s0_writedata;

    // Register writes, done bookkeeping and frame counting
    always_comb begin
        ctrl_d   = ctrl_q;
        sel_d    = sel_q;
        on_d     = on_q;
        off_d    = off_q;
        rep_d    = rep_q;
        done_d   = done_q;
        frames_d = frames_q + 32'(vs_rise);
`ifdef ANIM_SCHED_IRQ_EN
        irq_mask_d = irq_mask_q;
`endif
        if (s0_write) begin
            case (s0_address)
                ADDR_CTRL:   ctrl_d = s0_writedata[NUM_REGIONS-1:0];
                ADDR_STATUS: done_d = done_q & ~s0_writedata[STATUS_DONE_LSB +: NUM_REGIONS];
                ADDR_SEL: begin
                    if ({29'd0, s0_writedata[2:0]} < 32'(NUM_REGIONS)) sel_d = s0_writedata[2:0];
                end
                ADDR_TIMING: begin
                    on_d[sel_idx]  = s0_writedata[8 +: CNT_BITS];
                    off_d[sel_idx] = s0_writedata[0 +: CNT_BITS];
                end
                ADDR_REPEAT: rep_d[sel_idx] = s0_writedata[15:0];
`ifdef ANIM_SCHED_IRQ_EN
                ADDR_IRQ_MASK: irq_mask_d = s0_writedata[7:0];
`endif
                default: ;
            endcase
        end
        // A sequencer finishing on the same edge as a W1C keeps its bit set
        done_d = done_d | done_set;
`ifdef ANIM_SCHED_IRQ_EN
        irq_d = |(done_d & irq_mask_d[NUM_REGIONS-1:0]);
`endif
    end

    // Read mux; readdata is captured on s0_read and held otherwise
    always_comb begin
        rd_mux = '0;
        case (s0_address)
            ADDR_CTRL: rd_mux[NUM_REGIONS-1:0] = ctrl_q;
            ADDR_STATUS: begin
                rd_mux[STATUS_RUN_LSB +: NUM_REGIONS]  = running;
                rd_mux[STATUS_DONE_LSB +: NUM_REGIONS] = done_q;
            end
            ADDR_SEL: rd_mux[2:0] = sel_q;
            ADDR_TIMING: begin
                rd_mux[8 +: CNT_BITS] = on_q[sel_idx];
                rd_mux[0 +: CNT_BITS] = off_q[sel_idx];
            end
            ADDR_REPEAT: rd_mux[15:0] = rep_q[sel_idx];
            ADDR_FRAMES: rd_mux = frames_q;
`ifdef ANIM_SCHED_IRQ_EN
            ADDR_IRQ_MASK: rd_mux[7:0] = irq_mask_q;
`endif
            default: ;
        endcase
        rdata_d = s0_read ? rd_mux : rdata_q;
    end

    // Register file and bus-side state
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) begin
            v_sync_q <= 1'b0;
            ctrl_q   <= '0;
            sel_q    <= '0;
            done_q   <= '0;
            frames_q <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                on_q[i]  <= CNT_BITS'(1);
                off_q[i] <= '0;
                rep_q[i] <= '0;
            end
`ifdef ANIM_SCHED_IRQ_EN
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            v_sync_q <= v_sync;
            ctrl_q   <= ctrl_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            frames_q <= frames_d;
            rdata_q  <= rdata_d;
            on_q     <= on_d;
            off_q    <= off_d;
            rep_q    <= rep_d;
`ifdef ANIM_SCHED_IRQ_EN
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
`endif
        end
    end

    assign s0_readdata = rdata_q;
`ifdef ANIM_SCHED_IRQ_EN
    assign irq = irq_q;
`endif

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        anim_region_fsm #(.CNT_BITS(CNT_BITS)) u_fsm (
            .clk        (clock_clk),
            .rst        (reset_rst),
            .enable     (ctrl_q[g]),
            .vs_rise    (vs_rise),
            .on_frames  (on_q[g]),
            .off_frames (off_q[g]),
            .repeat_cnt (rep_q[g]),
            .trigger    (event_trigger[g]),
            .running    (running[g]),
            .done_set   (done_set[g])
        );
    end

endmodule

// File: tb/tb_animation_scheduler.sv
// Directed bench for animation_scheduler with hand-computed expectations.
module tb_animation_scheduler;

    logic        clock_clk = 1'b0;
    logic        reset_rst = 1'b1;
    logic        v_sync = 1'b0;
    logic [2:0]  s0_address = '0;
    logic        s0_write = 1'b0;
    logic [31:0] s0_writedata = '0;
    logic        s0_read = 1'b0;
    logic [31:0] s0_readdata;
    logic [1:0]  event_trigger;
`ifdef ANIM_SCHED_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int nframes  = 0;
    logic [31:0] rd, f0;
    int exp_r0[7] = '{1, 1, 0, 1, 1, 0, 0};

    always #5 clock_clk = ~clock_clk;

    animation_scheduler #(.NUM_REGIONS(2), .CNT_BITS(8)) dut (
        .clock_clk     (clock_clk),
        .reset_rst     (reset_rst),
        .v_sync        (v_sync),
        .s0_address    (s0_address),
        .s0_write      (s0_write),
        .s0_writedata  (s0_writedata),
        .s0_read       (s0_read),
        .s0_readdata   (s0_readdata),
        .event_trigger (event_trigger)
`ifdef ANIM_SCHED_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock_clk);
        s0_address = a; s0_writedata = d; s0_write = 1'b1;
        @(negedge clock_clk);
        s0_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clock_clk);
        s0_address = a; s0_read = 1'b1;
        @(negedge clock_clk);
        s0_read = 1'b0;
        d = s0_readdata;
    endtask

    // One frame: v_sync held high for two cycles
    task automatic frame();
        @(negedge clock_clk);
        v_sync = 1'b1;
        nframes++;
        repeat (2) @(negedge clock_clk);
        v_sync = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock_clk);
        check("rst_trig", 32'(event_trigger), 32'h0);
        check("rst_rdata", s0_readdata, 32'h0);
        reset_rst = 1'b0;

        // Reset values of the register map
        bus_read(3'd0, rd); check("rst_ctrl", rd, 32'h0);
        bus_read(3'd1, rd); check("rst_status", rd, 32'h0);
        bus_read(3'd2, rd); check("rst_sel", rd, 32'h0);
        bus_read(3'd3, rd); check("rst_timing", rd, 32'h100);
        bus_read(3'd4, rd); check("rst_repeat", rd, 32'h0);
        bus_read(3'd5, rd); check("rst_frames", rd, 32'h0);
        bus_read(3'd6, rd); check("rst_addr6", rd, 32'h0);
        bus_read(3'd7, rd); check("rst_addr7", rd, 32'h0);

        // SEL write outside the region range is dropped
        bus_write(3'd2, 32'd1);
        bus_write(3'd2, 32'd5);
        bus_read(3'd2, rd); check("sel_ignore", rd, 32'h1);

        // Region 0: on 2, off 1, repeat 2
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'h0201);
        bus_write(3'd4, 32'd2);
`ifdef ANIM_SCHED_IRQ_EN
        bus_write(3'd6, 32'd1);
`endif
        bus_write(3'd0, 32'd1);
        for (int i = 0; i < 7; i++) begin
            frame();
            check($sformatf("r0_frame%0d", i), 32'(event_trigger), 32'(exp_r0[i]));
            if (i == 0) begin
                bus_read(3'd1, rd); check("r0_running", rd, 32'h1);
            end
        end
        bus_read(3'd1, rd); check("r0_done", rd, 32'h100);
        bus_read(3'd5, rd); check("frames_7", rd, 32'(nframes));
`ifdef ANIM_SCHED_IRQ_EN
        check("irq_set", 32'(irq), 32'h1);
`endif
        bus_write(3'd1, 32'h100);
        @(negedge clock_clk);
`ifdef ANIM_SCHED_IRQ_EN
        check("irq_clr", 32'(irq), 32'h0);
`endif
        bus_read(3'd1, rd); check("done_w1c", rd, 32'h0);
        bus_write(3'd0, 32'd0);

        // Region 1: on 1, off 0, infinite
        bus_write(3'd2, 32'd1);
        bus_write(3'd3, 32'h0100);
        bus_write(3'd4, 32'd0);
        bus_write(3'd0, 32'd2);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("r1_frame%0d", i), 32'(event_trigger), 32'h2);
        end
        bus_read(3'd1, rd); check("r1_running", rd, 32'h2);
        bus_read(3'd3, rd); check("r1_timing", rd, 32'h100);
        @(negedge clock_clk);
        s0_address = 3'd0; s0_writedata = 32'd0; s0_write = 1'b1;
        @(negedge clock_clk);
        s0_write = 1'b0;
        check("r1_dis_hold", 32'(event_trigger), 32'h2);
        @(negedge clock_clk);
        check("r1_dis_fall", 32'(event_trigger), 32'h0);

        // Region 0 armed without frames
        bus_write(3'd2, 32'd0);
        bus_read(3'd3, rd); check("r0_timing", rd, 32'h201);
        bus_write(3'd0, 32'd1);
        repeat (20) @(negedge clock_clk);
        check("arm_trig", 32'(event_trigger), 32'h0);
        bus_read(3'd1, rd); check("arm_running", rd, 32'h1);

        // Disable on the same edge as a frame edge
        frame();
        check("pre_dis_on", 32'(event_trigger), 32'h1);
        bus_read(3'd5, f0);
        @(negedge clock_clk);
        v_sync = 1'b1; nframes++;
        s0_address = 3'd0; s0_writedata = 32'd0; s0_write = 1'b1;
        @(negedge clock_clk);
        s0_write = 1'b0; v_sync = 1'b0;
        @(negedge clock_clk);
        check("same_edge_trig", 32'(event_trigger), 32'h0);
        bus_read(3'd1, rd); check("same_edge_status", rd, 32'h0);
        bus_read(3'd5, rd); check("same_edge_frames", rd, f0 + 32'd1);
        check("frames_total", rd, 32'(nframes));

        // Asynchronous reset mid-run
        bus_write(3'd2, 32'd1);
        bus_write(3'd0, 32'd2);
        frame();
        check("pre_rst_trig", 32'(event_trigger), 32'h2);
        @(negedge clock_clk);
        #2 reset_rst = 1'b1;
        #1 check("async_rst_trig", 32'(event_trigger), 32'h0);
        @(negedge clock_clk);
        reset_rst = 1'b0;
        bus_read(3'd0, rd); check("post_rst_ctrl", rd, 32'h0);
        bus_read(3'd5, rd); check("post_rst_frames", rd, 32'h0);
        bus_read(3'd3, rd); check("post_rst_timing", rd, 32'h100);
        bus_read(3'd1, rd); check("post_rst_status", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
